// File: rtl/player_motion_ctrl.sv
// Player sprite motion: synchronised keys drive a speed-ramping mover that
// updates the sprite position once per frame at the start of vertical blanking.
module player_motion_ctrl #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int START_X     = 312,
  parameter int START_Y     = 232,
  parameter int MAX_SPEED   = 4,
  parameter int RAMP_FRAMES = 4
) (
  input  logic       Master_Clock_In,
  input  logic       Reset_N_In,
  input  logic       Up,
  input  logic       Down,
  input  logic       Left,
  input  logic       Right,
  input  logic [9:0] Val_Row_In,
  input  logic [9:0] Val_Col_In,
  output logic [9:0] Pos_X_Out,
  output logic [9:0] Pos_Y_Out,
  output logic       Frame_Tick_Out,
  output logic       Moving_Out
);

  localparam int SW = $clog2(MAX_SPEED + 1);
  localparam int RW = $clog2(RAMP_FRAMES + 1);
  localparam logic signed [10:0] XMAX = 11'(H_ACTIVE - SPRITE_W);
  localparam logic signed [10:0] YMAX = 11'(V_ACTIVE - SPRITE_H);

  typedef enum logic [1:0] {REST, ACCEL, CRUISE} state_t;

  state_t          st, st_n;
  logic [SW-1:0]   spd, spd_n, spd_inc;
  logic [RW-1:0]   ramp, ramp_n;
  logic [3:0]      key_s1, key_s2;
  logic            cond_q, cond_p, rise;
  logic            u, d, l, r;
  logic            dx_pos, dx_neg, dy_pos, dy_neg, dir;
  logic signed [10:0] step, x_n, y_n, x_c, y_c;

  assign {u, d, l, r} = key_s2;
  assign dx_pos = r & ~l;
  assign dx_neg = l & ~r;
  assign dy_pos = d & ~u;
  assign dy_neg = u & ~d;
  assign dir    = dx_pos | dx_neg | dy_pos | dy_neg;
  assign rise   = cond_q & ~cond_p;
  assign spd_inc = spd + 1'b1;

  always_comb begin
    st_n   = st;
    spd_n  = spd;
    ramp_n = ramp;
    if (!dir) begin
      st_n   = REST;
      spd_n  = '0;
      ramp_n = '0;
    end else begin
      unique case (st)
        REST: begin
          spd_n  = SW'(1);
          ramp_n = '0;
          st_n   = (MAX_SPEED == 1) ? CRUISE : ACCEL;
        end
        ACCEL: begin
          if (ramp == RW'(RAMP_FRAMES - 1)) begin
            spd_n  = spd_inc;
            ramp_n = '0;
            if (spd_inc == SW'(MAX_SPEED)) st_n = CRUISE;
          end else begin
            ramp_n = ramp + 1'b1;
          end
        end
        CRUISE: spd_n = SW'(MAX_SPEED);
        default: begin
          st_n  = REST;
          spd_n = '0;
        end
      endcase
    end
  end

  // Signed 11-bit sum so a step past either edge clamps instead of wrapping
  always_comb begin
    step = 11'(spd_n);
    x_n  = $signed({1'b0, Pos_X_Out});
    y_n  = $signed({1'b0, Pos_Y_Out});
    if (dx_pos) x_n = x_n + step;
    if (dx_neg) x_n = x_n - step;
    if (dy_pos) y_n = y_n + step;
    if (dy_neg) y_n = y_n - step;
    x_c = x_n;
    y_c = y_n;
    if (x_n < 0) x_c = '0;
    else if (x_n > XMAX) x_c = XMAX;
    if (y_n < 0) y_c = '0;
    else if (y_n > YMAX) y_c = YMAX;
  end

  always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      key_s1         <= '0;
      key_s2         <= '0;
      cond_q         <= 1'b0;
      cond_p         <= 1'b0;
      st             <= REST;
      spd            <= '0;
      ramp           <= '0;
      Pos_X_Out      <= 10'(START_X);
      Pos_Y_Out      <= 10'(START_Y);
      Frame_Tick_Out <= 1'b0;
      Moving_Out     <= 1'b0;
    end else begin
      key_s1         <= {Up, Down, Left, Right};
      key_s2         <= key_s1;
      cond_q         <= (Val_Row_In == 10'(V_ACTIVE)) &&
                        (Val_Col_In == 10'd0);
      cond_p         <= cond_q;
      Frame_Tick_Out <= rise;
      if (rise) begin
        st         <= st_n;
        spd        <= spd_n;
        ramp       <= ramp_n;
        Pos_X_Out  <= x_c[9:0];
        Pos_Y_Out  <= y_c[9:0];
        Moving_Out <= (st_n != REST);
      end
    end
  end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: compressed frames, table vectors,
// directed corner sequences and random keys against a frame-level model.
module tb_player_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up, down, left, right;
  logic [9:0] row, col;
  logic [9:0] pos_x, pos_y;
  logic       tick, moving;

  player_motion_ctrl dut (
    .Master_Clock_In(clk),
    .Reset_N_In(rst_n),
    .Up(up),
    .Down(down),
    .Left(left),
    .Right(right),
    .Val_Row_In(row),
    .Val_Col_In(col),
    .Pos_X_Out(pos_x),
    .Pos_Y_Out(pos_y),
    .Frame_Tick_Out(tick),
    .Moving_Out(moving)
  );

  always #20 clk = ~clk;

  localparam int XMAX = 624;
  localparam int YMAX = 464;
  localparam int MAXS = 4;
  localparam int RAMP = 4;
  localparam int FRAME_NS = 10 * 40;

  int errors = 0;
  int checks = 0;
  int tick_count = 0;
  time last_tick = 0;
  time gap = 0;

  int mx, my, held;

  typedef struct {
    logic [3:0] keys;
    int x;
    int y;
    logic mv;
  } vec_t;

  vec_t tbl[14];

  always @(negedge clk) begin
    if (tick) begin
      gap = $time - last_tick;
      last_tick = $time;
      tick_count++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Frame-level model: speed follows from how many consecutive frames
  // a direction has been held.
  task automatic model_step(input logic [3:0] k);
    int dx, dy, s;
    dx = (k[0] && !k[1]) ? 1 : ((k[1] && !k[0]) ? -1 : 0);
    dy = (k[2] && !k[3]) ? 1 : ((k[3] && !k[2]) ? -1 : 0);
    if (dx != 0 || dy != 0) begin
      held++;
      s = 1 + (held - 1) / RAMP;
      if (s > MAXS) s = MAXS;
    end else begin
      held = 0;
      s = 0;
    end
    mx = clampi(mx + dx * s, XMAX);
    my = clampi(my + dy * s, YMAX);
  endtask

  task automatic model_reset();
    mx = 312;
    my = 232;
    held = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    row = 10'd100;
    col = 10'd5;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  // One compressed frame: keys settle, then row 480/col 0 for one cycle
  task automatic frame(input logic [3:0] k, input string name);
    int t0;
    @(negedge clk);
    {up, down, left, right} = k;
    row = 10'd100;
    col = 10'd3;
    repeat (4) @(negedge clk);
    t0 = tick_count;
    row = 10'd480;
    col = 10'd0;
    @(negedge clk);
    col = 10'd1;
    repeat (4) @(negedge clk);
    row = 10'd481;
    model_step(k);
    chk({name, " ticks"}, tick_count - t0, 1);
    chk({name, " x"}, int'(pos_x), mx);
    chk({name, " y"}, int'(pos_y), my);
    chk({name, " moving"}, int'(moving), (held != 0) ? 1 : 0);
  endtask

  initial begin
    int t0, xs;
    logic [3:0] k;
    rst_n = 1'b0;
    {up, down, left, right} = 4'b0000;
    row = 10'd100;
    col = 10'd5;
    model_reset();

    for (int i = 0; i < 13; i++) begin
      tbl[i].keys = 4'b0001;
      tbl[i].y = 232;
      tbl[i].mv = 1'b1;
    end
    tbl[0].x = 313;  tbl[1].x = 314;  tbl[2].x = 315;  tbl[3].x = 316;
    tbl[4].x = 318;  tbl[5].x = 320;  tbl[6].x = 322;  tbl[7].x = 324;
    tbl[8].x = 327;  tbl[9].x = 330;  tbl[10].x = 333; tbl[11].x = 336;
    tbl[12].x = 340;
    tbl[13].keys = 4'b0000;
    tbl[13].x = 340;
    tbl[13].y = 232;
    tbl[13].mv = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset x", int'(pos_x), 312);
    chk("reset y", int'(pos_y), 232);
    chk("reset tick", int'(tick), 0);
    chk("reset moving", int'(moving), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      frame(4'b0000, "idle");
      if (i > 0) chk("tick gap", int'(gap), FRAME_NS);
    end

    for (int i = 0; i < 14; i++) begin
      frame(tbl[i].keys, "ramp");
      chk("tbl x", int'(pos_x), tbl[i].x);
      chk("tbl y", int'(pos_y), tbl[i].y);
      chk("tbl moving", int'(moving), int'(tbl[i].mv));
    end

    do_reset();
    for (int i = 0; i < 100; i++) frame(4'b0010, "left edge");
    chk("left clamp", int'(pos_x), 0);
    for (int i = 0; i < 100; i++) frame(4'b0100, "down edge");
    chk("down clamp", int'(pos_y), 464);

    do_reset();
    frame(4'b0011, "l+r");
    chk("l+r x", int'(pos_x), 312);
    chk("l+r moving", int'(moving), 0);
    frame(4'b1011, "l+r+u");
    chk("l+r+u y", int'(pos_y), 231);
    chk("l+r+u moving", int'(moving), 1);
    frame(4'b0000, "stop");

    // Short Up pulse between ticks must not move the sprite
    @(negedge clk);
    up = 1'b1;
    repeat (3) @(negedge clk);
    up = 1'b0;
    repeat (3) @(negedge clk);
    frame(4'b0000, "glitch");
    chk("glitch y", int'(pos_y), 231);
    frame(4'b1000, "up once");
    chk("up once y", int'(pos_y), 230);
    frame(4'b0000, "up rel");

    do_reset();
    for (int i = 0; i < 53; i++) frame(4'b0001, "to 500");
    chk("cruise x", int'(pos_x), 500);
    @(negedge clk);
    #5 rst_n = 1'b0;
    #1;
    chk("async x", int'(pos_x), 312);
    chk("async y", int'(pos_y), 232);
    chk("async tick", int'(tick), 0);
    chk("async moving", int'(moving), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    t0 = tick_count;
    repeat (10) @(negedge clk);
    chk("no tick after rst", tick_count - t0, 0);
    frame(4'b0001, "post rst");
    chk("post rst x", int'(pos_x), 313);

    do_reset();
    for (int i = 0; i < 200; i++) begin
      xs = int'($urandom_range(0, 3));
      k = (xs == 0) ? 4'($urandom) : ((xs == 1) ? 4'b0000 : k);
      if (i == 0) k = 4'($urandom);
      frame(k, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
